// File: rtl/xor_stage_pkg.sv
// ---------------------------------------------------------------------------
// xor_stage_pkg
//   Definitions shared by the XOR compare stage and its downstream
//   mismatch-window monitor (xor_mismatch_window).
//
//   Contents:
//     mw_state_e      monitor FSM state encoding
//     DEFAULT_WINDOW  default number of valid samples per window; this value
//                     is also used by the XOR stage's bench
//     DEFAULT_CNT_W   default counter width matching DEFAULT_WINDOW
//     min_cnt_w()     smallest counter width that can hold 0..window
// ---------------------------------------------------------------------------
package xor_stage_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } mw_state_e;

  localparam int DEFAULT_WINDOW = 16;
  localparam int DEFAULT_CNT_W  = 5;

  // The mismatch count can reach the window size itself, so the counter
  // needs room for WINDOW + 1 distinct values.
  function automatic int min_cnt_w(input int window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/xor_mismatch_window.sv
// ---------------------------------------------------------------------------
// xor_mismatch_window
//   Per-window pattern-compare monitor that sits directly behind the
//   registered XOR stage. Every valid XOR bit is a mismatch flag. The block
//   counts mismatches over WINDOW valid samples and then offers the count on
//   a valid/ready result port. It holds the count until the consumer accepts
//   it.
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   IDLE   | waiting for start; samples are ignored
//   ACCUM  | counting valid samples and mismatches; start is ignored
//   REPORT | result is presented and held until res_valid && res_ready
//
//   Ports:
//     clk         in   1      clock; all state changes on the rising edge
//     rst_n       in   1      asynchronous reset, active low
//     start       in   1      request a window (IDLE, or REPORT on accept)
//     diff_valid  in   1      diff_bit carries a valid sample this cycle
//     diff_bit    in   1      XOR-stage output, 1 = mismatch
//     busy        out  1      high in ACCUM and REPORT
//     res_valid   out  1      result available
//     res_ready   in   1      consumer accepts the result
//     res_count   out  CNT_W  mismatches seen in the finished window
//     res_clean   out  1      1 when res_count == 0
//
//   Every output comes from a register. start and res_ready only steer the
//   next state, so there is no combinational path from them to an output.
// ---------------------------------------------------------------------------
module xor_mismatch_window
  import xor_stage_pkg::*;
#(
  parameter int WINDOW = DEFAULT_WINDOW,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             diff_valid,
  input  logic             diff_bit,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic             res_clean
);

  // Catch a counter that is too narrow for the window at elaboration time.
  // Without this check, the count would wrap silently.
  if (WINDOW < 1) begin : g_bad_window
    $error("xor_mismatch_window: WINDOW must be at least 1");
  end
  if (CNT_W < min_cnt_w(WINDOW)) begin : g_bad_cnt_w
    $error("xor_mismatch_window: CNT_W too narrow for WINDOW");
  end

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

  mw_state_e        state_q;
  mw_state_e        state_d;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [CNT_W-1:0] mismatch_next;
  logic             clear_cnt;
  logic             take_sample;
  logic             last_sample;

  // The running count includes the sample on the current edge. When this is
  // the final sample of the window, this value goes straight into the result.
  assign mismatch_next = mismatch_cnt + CNT_W'(diff_bit);

  // Next-state and control decode
  always_comb begin
    state_d     = state_q;
    clear_cnt   = 1'b0;
    take_sample = 1'b0;
    last_sample = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ACCUM;
          clear_cnt = 1'b1;
        end
      end

      ACCUM: begin
        if (diff_valid) begin
          take_sample = 1'b1;
          if (sample_cnt == LAST_IDX) begin
            last_sample = 1'b1;
            state_d     = REPORT;
          end
        end
      end

      REPORT: begin
        // When start arrives on the accept edge, the next window begins with
        // no idle cycle in between.
        if (res_ready) begin
          if (start) begin
            state_d   = ACCUM;
            clear_cnt = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sample_cnt   <= '0;
      mismatch_cnt <= '0;
      res_count    <= '0;
      res_clean    <= 1'b0;
    end else begin
      state_q <= state_d;

      if (clear_cnt) begin
        sample_cnt   <= '0;
        mismatch_cnt <= '0;
      end else if (take_sample) begin
        sample_cnt   <= sample_cnt + 1'b1;
        mismatch_cnt <= mismatch_next;
      end

      // The result registers change only when a window closes. After an
      // accept, they keep the last report until the next window closes.
      if (last_sample) begin
        res_count <= mismatch_next;
        res_clean <= (mismatch_next == '0);
      end
    end
  end

  // Both flags come straight from the state register, so they need no
  // separate flops and cannot glitch on inputs.
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == REPORT);

endmodule
